// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a single uart_tx: grants one requester, launches its bytes, enforces
// an inter-frame gap and rotates on packet end, quota exhaustion or withdrawal.
module uart_tx_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int GAP_CLKS = 27,
   parameter int LOCK_MAX = 16
) (
   input  logic                 clk_3125,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   ack,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_done,
   output logic                 busy
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(LOCK_MAX + 1);
   localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, GAP} state_t;

   state_t              state_q, state_d;
   logic [IW-1:0]       own_q, own_d;
   logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]       byte_cnt_q, byte_cnt_d;
   logic                last_q, last_d;
   logic [GW-1:0]       gap_q, gap_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic                tx_start_q, tx_start_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                busy_q, busy_d;

   logic [7:0]          req_byte [NUM_REQ];
   logic                found;
   logic [IW-1:0]       pick;
   logic [IW-1:0]       own_next;
   logic                release_ok;
   logic                decide;
   int                  idx;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
      assign req_byte[i] = req_data[8*i +: 8];
   end

   // Scan downward so the last hit is the lowest offset from rr_ptr.
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr_q;
      idx   = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (req[IW'(idx)]) begin
            found = 1'b1;
            pick  = IW'(idx);
         end
      end
   end

   assign own_next   = (own_q == IW'(NUM_REQ - 1)) ? '0 : own_q + IW'(1);
   assign release_ok = last_q || (byte_cnt_q == CW'(LOCK_MAX)) || !req[own_q];

   always_comb begin
      state_d    = state_q;
      own_d      = own_q;
      rr_ptr_d   = rr_ptr_q;
      byte_cnt_d = byte_cnt_q;
      last_d     = last_q;
      gap_d      = gap_q;
      grant_d    = grant_q;
      ack_d      = '0;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      decide     = 1'b0;

      case (state_q)
         IDLE: begin
            if (found) begin
               own_d       = pick;
               grant_d     = '0;
               grant_d[pick] = 1'b1;
               byte_cnt_d  = '0;
               state_d     = LOAD;
            end
         end
         LOAD: begin
            if (req[own_q]) begin
               tx_data_d     = req_byte[own_q];
               tx_start_d    = 1'b1;
               ack_d[own_q]  = 1'b1;
               last_d        = req_last[own_q];
               byte_cnt_d    = byte_cnt_q + CW'(1);
               state_d       = WAIT_DONE;
            end else begin
               grant_d  = '0;
               rr_ptr_d = own_next;
               state_d  = IDLE;
            end
         end
         WAIT_DONE: begin
            // A done coincident with our own launch belongs to no frame of ours.
            if (tx_done && !tx_start_q) begin
               if (GAP_CLKS == 0) begin
                  decide = 1'b1;
               end else begin
                  gap_d   = GW'(GAP_CLKS);
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            if (gap_q <= GW'(1)) decide = 1'b1;
            else                 gap_d  = gap_q - GW'(1);
         end
         default: state_d = IDLE;
      endcase

      if (decide) begin
         if (release_ok) begin
            grant_d  = '0;
            rr_ptr_d = own_next;
            state_d  = IDLE;
         end else begin
            state_d  = LOAD;
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_3125 or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         own_q      <= '0;
         rr_ptr_q   <= '0;
         byte_cnt_q <= '0;
         last_q     <= 1'b0;
         gap_q      <= '0;
         grant_q    <= '0;
         ack_q      <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         own_q      <= own_d;
         rr_ptr_q   <= rr_ptr_d;
         byte_cnt_q <= byte_cnt_d;
         last_q     <= last_d;
         gap_q      <= gap_d;
         grant_q    <= grant_d;
         ack_q      <= ack_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
      end
   end

   assign grant    = grant_q;
   assign ack      = ack_q;
   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (default, and no-gap with quota 2) against a
// timestamp-driven scheduling model, directed scenarios plus randomized traffic.
module tb_uart_tx_arbiter;

   typedef struct {
      logic [7:0] d;
      logic       l;
   } item_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_s  [2];
   logic [31:0] data_s [2];
   logic [3:0]  last_s [2];
   logic        done_s [2];
   logic [3:0]  ack_o  [2];
   logic [3:0]  grant_o[2];
   logic        start_o[2];
   logic [7:0]  txd_o  [2];
   logic        busy_o [2];

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(27), .LOCK_MAX(16)) u_dut0 (
      .clk_3125(clk), .rst(rst), .req(req_s[0]), .req_data(data_s[0]), .req_last(last_s[0]),
      .ack(ack_o[0]), .grant(grant_o[0]), .tx_start(start_o[0]), .tx_data(txd_o[0]),
      .tx_done(done_s[0]), .busy(busy_o[0]));

   uart_tx_arbiter #(.NUM_REQ(4), .GAP_CLKS(0), .LOCK_MAX(2)) u_dut1 (
      .clk_3125(clk), .rst(rst), .req(req_s[1]), .req_data(data_s[1]), .req_last(last_s[1]),
      .ack(ack_o[1]), .grant(grant_o[1]), .tx_start(start_o[1]), .tx_data(txd_o[1]),
      .tx_done(done_s[1]), .busy(busy_o[1]));

   int vectors = 0;
   int miscompares = 0;
   int tcyc = 0;
   bit rnd = 0;

   // ---------------- behavioural model (event timestamps, not states) ----------------
   int         m_own[2], m_ptr[2], m_cnt[2], m_load[2], m_dec[2], m_launch[2];
   bit         m_last[2], m_wait[2];
   logic [3:0] e_grant[2], e_ack[2];
   logic       e_start[2], e_busy[2];
   logic [7:0] e_data[2];

   function automatic int gapk(int k);  return (k == 0) ? 27 : 0; endfunction
   function automatic int lockk(int k); return (k == 0) ? 16 : 2; endfunction

   task automatic m_reset(int k);
      m_own[k] = -1; m_ptr[k] = 0; m_cnt[k] = 0; m_load[k] = -1; m_dec[k] = -1;
      m_launch[k] = -1; m_last[k] = 0; m_wait[k] = 0;
      e_grant[k] = 0; e_ack[k] = 0; e_start[k] = 0; e_busy[k] = 0; e_data[k] = 8'h00;
   endtask

   task automatic m_release(int k);
      m_ptr[k] = (m_own[k] + 1) % 4;
      m_own[k] = -1;
      e_grant[k] = 4'b0000;
   endtask

   task automatic m_decide(int k, int c);
      if (m_last[k] || m_cnt[k] == lockk(k) || !req_s[k][m_own[k]]) m_release(k);
      else m_load[k] = c + 1;
   endtask

   task automatic m_step(int k, int c);
      int g;
      e_ack[k] = 0;
      e_start[k] = 0;
      if (m_own[k] < 0) begin
         g = -1;
         for (int j = 3; j >= 0; j--) if (req_s[k][(m_ptr[k] + j) % 4]) g = (m_ptr[k] + j) % 4;
         if (g >= 0) begin
            m_own[k] = g; m_cnt[k] = 0; m_load[k] = c + 1;
            e_grant[k] = 4'(1 << g);
         end
      end else if (c == m_load[k]) begin
         if (req_s[k][m_own[k]]) begin
            e_start[k] = 1;
            e_ack[k] = 4'(1 << m_own[k]);
            e_data[k] = data_s[k][8*m_own[k] +: 8];
            m_last[k] = last_s[k][m_own[k]];
            m_cnt[k]++;
            m_wait[k] = 1;
            m_launch[k] = c + 1;
         end else m_release(k);
      end else if (m_wait[k] && done_s[k] && c != m_launch[k]) begin
         m_wait[k] = 0;
         if (gapk(k) == 0) m_decide(k, c);
         else m_dec[k] = c + gapk(k);
      end else if (c == m_dec[k]) begin
         m_decide(k, c);
      end
      e_busy[k] = (m_own[k] >= 0);
   endtask

   // ---------------- stimulus environment ----------------
   item_t      qq[8][$];
   int         alog[2][$], glog[2][$], sgap[2][$];
   logic [7:0] dlog[2][$];
   int         cd[2], last_done[2];
   logic [3:0] prev_grant[2];

   function automatic int oh2i(logic [3:0] v);
      int r = -1;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, tcyc);
      end
   endtask

   task automatic present(int k, int i);
      item_t it;
      it = qq[k*4+i].pop_front();
      req_s[k][i] = 1'b1;
      data_s[k][8*i +: 8] = it.d;
      last_s[k][i] = it.l;
   endtask

   task automatic tick();
      item_t it;
      @(negedge clk);
      if (!rst) begin
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({grant_o[k], ack_o[k], start_o[k], txd_o[k], busy_o[k]} !==
                {e_grant[k], e_ack[k], e_start[k], e_data[k], e_busy[k]}) begin
               miscompares++;
               $display("FAIL model_cmp inst%0d cycle %0d: got g=%b a=%b s=%b d=%h b=%b required g=%b a=%b s=%b d=%h b=%b",
                        k, tcyc, grant_o[k], ack_o[k], start_o[k], txd_o[k], busy_o[k],
                        e_grant[k], e_ack[k], e_start[k], e_data[k], e_busy[k]);
            end
         end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) m_reset(k);
         else m_step(k, tcyc);
      end
      tcyc++;
      #1;
      for (int k = 0; k < 2; k++) begin
         done_s[k] = 1'b0;
         if (rst) cd[k] = 0;
         else begin
            if (cd[k] > 0) begin
               cd[k]--;
               if (cd[k] == 0) begin done_s[k] = 1'b1; last_done[k] = tcyc; end
            end
            if (start_o[k]) begin
               cd[k] = rnd ? int'($urandom_range(3, 40)) : 297;
               sgap[k].push_back(tcyc - last_done[k]);
               dlog[k].push_back(txd_o[k]);
            end
            if (rnd && $urandom_range(0, 63) == 0) done_s[k] = 1'b1;
            if (|ack_o[k]) alog[k].push_back(oh2i(ack_o[k]));
            if (grant_o[k] != prev_grant[k] && grant_o[k] != 0) glog[k].push_back(oh2i(grant_o[k]));
            prev_grant[k] = grant_o[k];
            for (int i = 0; i < 4; i++) begin
               if (ack_o[k][i]) begin
                  if (qq[k*4+i].size() > 0) present(k, i);
                  else req_s[k][i] = 1'b0;
               end else if (!req_s[k][i] && qq[k*4+i].size() > 0) begin
                  present(k, i);
               end else if (rnd && req_s[k][i] && $urandom_range(0, 299) == 0) begin
                  req_s[k][i] = 1'b0;
               end
               if (rnd && qq[k*4+i].size() < 3 && $urandom_range(0, 39) == 0) begin
                  it.d = 8'($urandom);
                  it.l = ($urandom_range(0, 2) == 0);
                  qq[k*4+i].push_back(it);
               end
            end
         end
      end
   endtask

   task automatic clear_env();
      for (int k = 0; k < 2; k++) begin
         req_s[k] = 0; data_s[k] = 0; last_s[k] = 0; done_s[k] = 0;
         cd[k] = 0; last_done[k] = 0; prev_grant[k] = 0;
         alog[k].delete(); glog[k].delete(); sgap[k].delete(); dlog[k].delete();
      end
      for (int n = 0; n < 8; n++) qq[n].delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_env();
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic bit cond(int k, int kind, int n);
      case (kind)
         0: return alog[k].size() >= n;
         1: return glog[k].size() >= n;
         2: return start_o[k] == 1'b1;
         3: return done_s[k] == 1'b1;
         default: return busy_o[k] == 1'b0;
      endcase
   endfunction

   task automatic wait_until(string nm, int k, int kind, int n, int bound);
      int t = 0;
      while (!cond(k, kind, n) && t < bound) begin tick(); t++; end
      vectors++;
      if (!cond(k, kind, n)) begin
         miscompares++;
         $display("FAIL timeout_%s: waited %0d cycles, event required within %0d", nm, t, bound);
      end
   endtask

   task automatic push(int n, logic [7:0] d, logic l);
      item_t it;
      it.d = d; it.l = l;
      qq[n].push_back(it);
   endtask

   initial begin
      clear_env();
      for (int k = 0; k < 2; k++) m_reset(k);

      // reset state
      do_reset();
      tick();
      chk("reset_grant", {28'd0, grant_o[0]}, 0);
      chk("reset_busy", {31'd0, busy_o[0]}, 0);
      chk("reset_txdata", {24'd0, txd_o[0]}, 0);

      // single byte from requester 2
      req_s[0][2] = 1'b1; data_s[0][23:16] = 8'h41; last_s[0][2] = 1'b1;
      tick();
      chk("single_grant_n1", {28'd0, grant_o[0]}, 32'b0100);
      chk("single_busy_n1", {31'd0, busy_o[0]}, 1);
      tick();
      chk("single_start_n2", {31'd0, start_o[0]}, 1);
      chk("single_ack_n2", {28'd0, ack_o[0]}, 32'b0100);
      chk("single_data", {24'd0, txd_o[0]}, 32'h41);
      wait_until("single_done", 0, 3, 0, 400);
      repeat (27) tick();
      chk("single_grant_gap_end", {28'd0, grant_o[0]}, 32'b0100);
      tick();
      chk("single_grant_rel", {28'd0, grant_o[0]}, 0);
      chk("single_busy_rel", {31'd0, busy_o[0]}, 0);
      chk("model_ptr_after_single", m_ptr[0], 3);
      req_s[0][0] = 1'b1; req_s[0][3] = 1'b1; last_s[0] = 4'b1001;
      tick();
      chk("rr_ptr3_pick", {28'd0, grant_o[0]}, 32'b1000);
      wait_until("single_drain", 0, 4, 0, 2000);

      // round robin, everyone busy
      do_reset();
      for (int i = 0; i < 4; i++) begin push(i, 8'(8'h80 + i), 1'b1); push(i, 8'(8'h90 + i), 1'b1); end
      wait_until("rr_grants", 0, 1, 5, 3000);
      for (int j = 0; j < 5; j++) chk("rr_order", (glog[0].size() > j) ? glog[0][j] : -1, j % 4);
      chk("rr_acks_per_grant", alog[0].size(), 4);

      // packet lock on requester 1 while requester 0 waits
      do_reset();
      push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
      tick();
      push(0, 8'h05, 1'b1);
      wait_until("pkt_acks", 0, 0, 4, 3000);
      for (int j = 0; j < 3; j++) begin
         chk("pkt_ack_owner", (alog[0].size() > j) ? alog[0][j] : -1, 1);
         chk("pkt_data", (dlog[0].size() > j) ? {24'd0, dlog[0][j]} : 32'hFFFF, 32'h10 + j);
      end
      chk("pkt_then_req0", (alog[0].size() > 3) ? alog[0][3] : -1, 0);
      chk("pkt_gap2", (sgap[0].size() > 1) ? sgap[0][1] : -1, 29);
      chk("pkt_gap3", (sgap[0].size() > 2) ? sgap[0][2] : -1, 29);

      // quota of 2 on the no-gap instance
      do_reset();
      for (int j = 0; j < 4; j++) push(4, 8'(8'h20 + j), 1'b0);
      tick();
      push(7, 8'h30, 1'b1);
      wait_until("quota_acks", 1, 0, 3, 3000);
      chk("quota_ack0", (alog[1].size() > 0) ? alog[1][0] : -1, 0);
      chk("quota_ack1", (alog[1].size() > 1) ? alog[1][1] : -1, 0);
      chk("quota_ack2", (alog[1].size() > 2) ? alog[1][2] : -1, 3);
      chk("quota_data2", (dlog[1].size() > 2) ? {24'd0, dlog[1][2]} : 32'hFFFF, 32'h30);

      // withdrawal in LOAD
      do_reset();
      tick();
      req_s[0][0] = 1'b1; data_s[0][7:0] = 8'h55; last_s[0][0] = 1'b1;
      tick();
      chk("wd_grant_load", {28'd0, grant_o[0]}, 32'b0001);
      req_s[0][0] = 1'b0;
      tick();
      chk("wd_no_start", {31'd0, start_o[0]}, 0);
      chk("wd_grant_rel", {28'd0, grant_o[0]}, 0);
      chk("model_ptr_after_wd", m_ptr[0], 1);
      req_s[0][0] = 1'b1; req_s[0][1] = 1'b1; last_s[0] = 4'b0011;
      tick();
      chk("wd_ptr1_pick", {28'd0, grant_o[0]}, 32'b0010);
      wait_until("wd_drain", 0, 4, 0, 2000);

      // reset in the middle of a frame
      req_s[0][2] = 1'b1; data_s[0][23:16] = 8'hA5; last_s[0][2] = 1'b1;
      wait_until("rst_start", 0, 2, 0, 50);
      repeat (100) tick();
      rst = 1'b1;
      #1;
      chk("midrst_grant", {28'd0, grant_o[0]}, 0);
      chk("midrst_ack", {28'd0, ack_o[0]}, 0);
      chk("midrst_start", {31'd0, start_o[0]}, 0);
      chk("midrst_data", {24'd0, txd_o[0]}, 0);
      chk("midrst_busy", {31'd0, busy_o[0]}, 0);
      clear_env();
      tick();
      tick();
      rst = 1'b0;
      tick();
      req_s[0][3] = 1'b1; last_s[0][3] = 1'b1;
      tick();
      chk("postrst_idle_grant", {28'd0, grant_o[0]}, 32'b1000);

      // randomized traffic on both instances
      do_reset();
      rnd = 1;
      repeat (20000) tick();
      rnd = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
